// File: rtl/bus_source_arbiter.sv
// bus_source_arbiter
//   Sequential arbiter choosing which datapath source drives the shared
//   32-bit bus. Produces a registered one-hot (or all-zero) grant for the
//   bus-select encoder, bounds tenure to MAX_HOLD cycles (0 = unlimited)
//   unless lock is held, and always leaves one undriven cycle between owners.
//
//   Build option: define BUS_ARB_ROUND_ROBIN_EN for rotating priority;
//   otherwise the lowest valid request index wins.
//
// Ports
//   clk     : clock, rising edge
//   clr     : synchronous active-high reset
//   req     : per-source request (0-15 R0-R15, 16 HI, 17 LO, 18 Zhigh,
//             19 Zlow, 20 PC, 21 MDR, 22 InPort, 23 C-sign)
//   lock    : current owner keeps the bus regardless of MAX_HOLD
//   grant   : registered one-hot bus-drive enable, or all-zero
//   owner   : binary index of granted source, 5'b11111 when none
//   busy    : grant is non-zero
//   timeout : one-cycle pulse in the gap after a forced release
module bus_source_arbiter #(
  parameter int unsigned NREQ     = 24,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] req,
  input  logic        lock,
  output logic [31:0] grant,
  output logic [4:0]  owner,
  output logic        busy,
  output logic        timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  // Requests at index NREQ and above can never win.
  localparam logic [31:0] VALID_MASK = 32'((64'd1 << NREQ) - 64'd1);

  state_t      state, state_nxt;
  logic [31:0] valid;
  logic [31:0] hold_cnt, hold_nxt;
  logic [31:0] grant_nxt;
  logic [4:0]  owner_nxt;
  logic        busy_nxt, timeout_nxt;
  logic        win_found;
  logic [4:0]  win_idx;

`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic [4:0]  ptr, ptr_nxt;
`endif

  always_comb begin
    valid = req & VALID_MASK;
  end

  // Winner search: a single index is selected, so grant stays one-hot.
  always_comb begin
    int unsigned pos;
    win_found = 1'b0;
    win_idx   = '0;
    pos       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
`ifdef BUS_ARB_ROUND_ROBIN_EN
      pos = 32'(ptr) + i;
      if (pos >= NREQ) pos = pos - NREQ;
`else
      pos = i;
`endif
      if (!win_found && valid[pos[4:0]]) begin
        win_found = 1'b1;
        win_idx   = pos[4:0];
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    owner_nxt   = owner;
    busy_nxt    = busy;
    timeout_nxt = 1'b0;
    hold_nxt    = hold_cnt;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    ptr_nxt     = ptr;
`endif
    case (state)
      IDLE, GAP: begin
        if (win_found) begin
          state_nxt          = GRANT;
          grant_nxt          = '0;
          grant_nxt[win_idx] = 1'b1;
          owner_nxt          = win_idx;
          busy_nxt           = 1'b1;
          hold_nxt           = 32'd1;
`ifdef BUS_ARB_ROUND_ROBIN_EN
          ptr_nxt = (win_idx == 5'(NREQ - 1)) ? 5'd0 : win_idx + 5'd1;
`endif
        end else begin
          state_nxt = IDLE;
          grant_nxt = '0;
          owner_nxt = '1;
          busy_nxt  = 1'b0;
        end
      end
      GRANT: begin
        if (!req[owner]) begin
          state_nxt = GAP;
          grant_nxt = '0;
          owner_nxt = '1;
          busy_nxt  = 1'b0;
        end else if (lock || (MAX_HOLD == 0) || (hold_cnt < MAX_HOLD)) begin
          // Counter saturates so a late lock drop releases on the next edge.
          if (hold_cnt < MAX_HOLD) hold_nxt = hold_cnt + 32'd1;
        end else begin
          state_nxt   = GAP;
          grant_nxt   = '0;
          owner_nxt   = '1;
          busy_nxt    = 1'b0;
          timeout_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        owner_nxt = '1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      grant    <= '0;
      owner    <= '1;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      ptr      <= '0;
`endif
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      owner    <= owner_nxt;
      busy     <= busy_nxt;
      timeout  <= timeout_nxt;
      hold_cnt <= hold_nxt;
`ifdef BUS_ARB_ROUND_ROBIN_EN
      ptr      <= ptr_nxt;
`endif
    end
  end

endmodule
